// File: rtl/sparse_vector_decoder.sv
// Zero-run-length sparse activation decoder: expands (value, zrun) entries into a dense, position-ordered stream.
// Optional macro SPARSE_DECODE_PREFETCH_EN overlaps the next entry fetch with EMIT for one element per cycle.
module sparse_vector_decoder #(
    parameter int DATA_W  = 16,
    parameter int ZRUN_W  = 4,
    parameter int MAX_LEN = 1024,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ZRUN_W-1:0] in_zrun,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_pos,
    output logic              out_last,
    output logic              done,
    output logic              err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ZERO, S_EMIT, S_PAD, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  pos_q, pos_d;
    logic [ZRUN_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              inFire, outFire, atEnd;

    assign busy        = (state_q != S_IDLE);
    assign out_valid   = (state_q == S_ZERO) || (state_q == S_EMIT) || (state_q == S_PAD);
    assign out_data    = (state_q == S_EMIT) ? value_q : '0;
    assign out_pos     = out_valid ? pos_q : '0;
    assign atEnd       = (pos_q == len_q - LEN_W'(1));
    assign out_last    = out_valid && atEnd;
    assign done        = (state_q == S_DONE);
    assign err_overrun = err_q;

`ifdef SPARSE_DECODE_PREFETCH_EN
    // Prefetch is gated by out_ready so an entry is only taken when the held element leaves too.
    assign in_ready = (state_q == S_FETCH) || (state_q == S_DRAIN) ||
                      ((state_q == S_EMIT) && !last_q && out_ready);
`else
    assign in_ready = (state_q == S_FETCH) || (state_q == S_DRAIN);
`endif

    assign inFire  = in_valid && in_ready;
    assign outFire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = vec_len;
                    pos_d   = '0;
                    err_d   = 1'b0;
                    state_d = (vec_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (inFire) begin
                    value_d = in_data;
                    cnt_d   = in_zrun;
                    last_d  = in_last;
                    state_d = (in_zrun != '0) ? S_ZERO : S_EMIT;
                end
            end
            // Reaching the final position before the entry's value is out is always an overrun.
            S_ZERO: begin
                if (outFire) begin
                    pos_d = pos_q + LEN_W'(1);
                    cnt_d = cnt_q - ZRUN_W'(1);
                    if (atEnd) begin
                        err_d   = 1'b1;
                        state_d = last_q ? S_DONE : S_DRAIN;
                    end else if (cnt_q == ZRUN_W'(1)) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (outFire) begin
                    pos_d = pos_q + LEN_W'(1);
                    if (atEnd) begin
                        if (!last_q) begin
                            err_d   = 1'b1;
                            state_d = (inFire && in_last) ? S_DONE : S_DRAIN;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (last_q) begin
                        state_d = S_PAD;
                    end else if (inFire) begin
                        value_d = in_data;
                        cnt_d   = in_zrun;
                        last_d  = in_last;
                        state_d = (in_zrun != '0) ? S_ZERO : S_EMIT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_PAD: begin
                if (outFire) begin
                    pos_d = pos_q + LEN_W'(1);
                    if (atEnd) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAIN: begin
                if (inFire && in_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sparse_vector_decoder.sv
// Self-checking bench for sparse_vector_decoder: a dense-vector model built from the entry list checks every output transfer.
// Build with +define+SPARSE_DECODE_PREFETCH_EN to expect the bubble-free timing.
module tb_sparse_vector_decoder;

    localparam int LEN_W = 11;
`ifdef SPARSE_DECODE_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  zrun;
        logic        last;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] vec_len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = '0;
    logic [3:0]       in_zrun = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [LEN_W-1:0] out_pos;
    logic             out_last;
    logic             done;
    logic             err_overrun;

    sparse_vector_decoder dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_zrun(in_zrun),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pos(out_pos), .out_last(out_last), .done(done), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    entry_t      entQ[$];
    entry_t      inQ[$];
    logic [15:0] expData[$];
    logic [15:0] gotData[$];
    int          xferCycles[$];
    int          acceptCycles[$];
    bit          expOverrun;
    int          testsRun = 0, testsFailed = 0;
    int          cycleNo = 0, expPos = 0, curLen = 0;
    int          doneCount = 0, busyCycles = 0, inReadyCycles = 0, outValidCycles = 0;
    logic [3:0]  readyPat = 4'b1111;
    int          patIdx = 0;
    bit          feedEn = 1'b0, checkEn = 1'b0, stalled = 1'b0;
    logic [15:0] heldData = '0;
    logic [LEN_W-1:0] heldPos = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic entry_t mk(input int d, input int z, input bit l);
        entry_t e;
        e.data = d[15:0];
        e.zrun = z[3:0];
        e.last = l;
        return e;
    endfunction

    // Model: concatenate "zrun zeros then value" up to the last entry, then pad or truncate to len.
    task automatic buildModel(input int len);
        logic [15:0] dense[$];
        bit ended;
        dense = {};
        ended = 1'b0;
        foreach (entQ[i]) begin
            if (!ended) begin
                for (int z = 0; z < int'(entQ[i].zrun); z++) dense.push_back(16'd0);
                dense.push_back(entQ[i].data);
                ended = entQ[i].last;
            end
        end
        expOverrun = (dense.size() > len);
        while (dense.size() < len) dense.push_back(16'd0);
        expData = {};
        for (int k = 0; k < len; k++) expData.push_back(dense[k]);
    endtask

    // Drive on the falling edge, sample 3 time units later, before the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            in_valid = feedEn && (inQ.size() > 0);
            if (inQ.size() > 0) begin
                in_data = inQ[0].data;
                in_zrun = inQ[0].zrun;
                in_last = inQ[0].last;
            end else begin
                in_data = '0;
                in_zrun = '0;
                in_last = 1'b0;
            end
            out_ready = readyPat[patIdx % 4];
            patIdx++;
            #3;
            cycleNo++;
            if (checkEn) begin
                if (busy) busyCycles++;
                if (in_ready) inReadyCycles++;
                if (out_valid) outValidCycles++;
                if (done) doneCount++;
                if (stalled) begin
                    checkOutput("stall out_valid", out_valid, 1);
                    checkOutput("stall out_data", out_data, heldData);
                    checkOutput("stall out_pos", out_pos, heldPos);
                end
                if (out_valid && !out_ready && in_valid) checkOutput("accept while pending", in_ready, 0);
                if (out_valid && out_ready) begin
                    xferCycles.push_back(cycleNo);
                    gotData.push_back(out_data);
                    if (expData.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpected output: got data %0d at pos %0d, expected none", out_data, out_pos);
                    end else begin
                        checkOutput("out_data", out_data, expData.pop_front());
                        checkOutput("out_pos", out_pos, expPos);
                        checkOutput("out_last", out_last, (expPos == curLen - 1));
                        expPos++;
                    end
                end
                stalled  = out_valid && !out_ready;
                heldData = out_data;
                heldPos  = out_pos;
            end
            if (in_valid && in_ready) begin
                acceptCycles.push_back(cycleNo);
                void'(inQ.pop_front());
            end
        end
    end

    task automatic startVector(input int len, input logic [3:0] pat);
        buildModel(len);
        inQ = entQ;
        curLen = len;
        expPos = 0;
        readyPat = pat;
        patIdx = 0;
        gotData = {};
        xferCycles = {};
        acceptCycles = {};
        doneCount = 0;
        busyCycles = 0;
        inReadyCycles = 0;
        outValidCycles = 0;
        stalled = 1'b0;
        feedEn = 1'b1;
        @(negedge clk);
        start = 1'b1;
        vec_len = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
        #4;
        checkOutput("err cleared on start", err_overrun, 0);
    endtask

    task automatic applyStimulus(input int len, input logic [3:0] pat);
        startVector(len, pat);
        for (int i = 0; i < 300; i++) begin
            if (doneCount != 0) break;
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        #4;
        checkOutput("done single pulse", doneCount, 1);
        checkOutput("outputs remaining", expData.size(), 0);
        checkOutput("entries not consumed", inQ.size(), 0);
        checkOutput("err_overrun", err_overrun, expOverrun);
        checkOutput("busy after done", busy, 0);
    endtask

    task automatic checkLiteral(input string name, input logic [15:0] lit[$]);
        checkOutput({name, " count"}, gotData.size(), lit.size());
        foreach (lit[i]) begin
            if (i < gotData.size()) checkOutput(name, gotData[i], lit[i]);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #3;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset out_pos", out_pos, 0);
        checkOutput("reset out_last", out_last, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err_overrun", err_overrun, 0);
        rst = 1'b0;
        checkEn = 1'b1;

        entQ = '{mk(5, 1, 0), mk(7, 0, 1)};
        applyStimulus(6, 4'b1111);
        checkLiteral("t1 data", '{16'd0, 16'd5, 16'd7, 16'd0, 16'd0, 16'd0});
        if (xferCycles.size() > 0 && acceptCycles.size() > 0)
            checkOutput("t1 first output latency", xferCycles[0] - acceptCycles[0], 1);
        else checkOutput("t1 latency samples", xferCycles.size() * acceptCycles.size(), 1);

        entQ = {};
        applyStimulus(0, 4'b1111);
        checkOutput("t2 busy cycles", busyCycles, 1);
        checkOutput("t2 in_ready cycles", inReadyCycles, 0);
        checkOutput("t2 out_valid cycles", outValidCycles, 0);

        entQ = '{mk(5, 1, 0), mk(7, 0, 1)};
        applyStimulus(6, 4'b1001);
        checkLiteral("t3 data", '{16'd0, 16'd5, 16'd7, 16'd0, 16'd0, 16'd0});

        entQ = '{mk(9, 2, 0), mk(4, 0, 0), mk(8, 0, 1)};
        applyStimulus(3, 4'b1111);
        checkLiteral("t4 data", '{16'd0, 16'd0, 16'd9});
        checkOutput("t4 overrun flag", err_overrun, 1);

        entQ = '{mk(0, 15, 0), mk(0, 0, 1)};
        applyStimulus(4, 4'b1111);
        checkLiteral("t5 data", '{16'd0, 16'd0, 16'd0, 16'd0});
        checkOutput("t5 overrun flag", err_overrun, 1);

        // Reset while the decoder is mid-way through a zero run.
        entQ = '{mk(0, 15, 0)};
        startVector(4, 4'b1111);
        for (int i = 0; i < 50; i++) begin
            if (gotData.size() >= 2) break;
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        rst = 1'b1;
        checkEn = 1'b0;
        @(negedge clk);
        #4;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst in_ready", in_ready, 0);
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst out_data", out_data, 0);
        checkOutput("rst out_pos", out_pos, 0);
        checkOutput("rst out_last", out_last, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst err_overrun", err_overrun, 0);
        rst = 1'b0;
        feedEn = 1'b0;
        inQ = {};
        expData = {};
        doneCount = 0;
        stalled = 1'b0;
        checkEn = 1'b1;
        repeat (4) @(negedge clk);
        #4;
        checkOutput("no done after reset", doneCount, 0);
        checkOutput("idle after reset", busy, 0);

        entQ = '{mk(1, 0, 0), mk(2, 0, 0), mk(3, 0, 0), mk(4, 0, 1)};
        applyStimulus(4, 4'b1111);
        checkLiteral("t6 data", '{16'd1, 16'd2, 16'd3, 16'd4});
        if (xferCycles.size() == 4) begin
            for (int i = 1; i < 4; i++) checkOutput("t6 element spacing", xferCycles[i] - xferCycles[i-1], GAP);
        end else begin
            checkOutput("t6 transfer count", xferCycles.size(), 4);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
